usb_rx_stream_buffer: RTL and testbench

- Downstream stage of the FX3 slave-FIFO stream-out read controller.
- Observes that controller's active-low read strobe and the 32-bit USB data bus, and compensates for the FX3 read latency so each read strobe captures exactly one word.
- Buffers captured words in a small FIFO and presents them as a valid/ready stream to the FPGA fabric.
- Drives a hold signal back to the read controller so that in-flight words can never overflow the buffer.

---
 rtl/usb_rx_stream_buffer.sv | 172 +++++++++++++++++
 tb/tb_usb_rx_stream_buffer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_stream_buffer
// Description : Receive-side buffer behind the FX3 slave-FIFO read controller.
//               Watches the controller's active-low read strobe (slrd), delays
//               it by the FX3 read latency so that every strobe captures
//               exactly one word from usb_data, queues the captured words in a
//               small FIFO and presents them as a valid/ready stream. A
//               combinational hold (rx_hold) tells the controller to stop
//               strobing once every free slot is spoken for.
//
// Ports       : clk        - system clock (shared with the read controller)
//               rst        - synchronous active-high reset
//               slrd       - read strobe from the controller, active low
//               usb_data   - FX3 data bus
//               rx_hold    - 1 = controller must keep slrd high this cycle
//               m_data     - stream data (FIFO head, straight from storage)
//               m_valid    - stream valid (FIFO not empty)
//               m_ready    - stream ready from the consumer
//               word_count - total words accepted into the FIFO (wraps)
//               overflow   - sticky, a captured word was dropped
//
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_stream_buffer #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 8,   // power of two, >= 4
    parameter int RD_LATENCY = 2    // 1..3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              slrd,
    input  logic [DATA_W-1:0] usb_data,
    output logic              rx_hold,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       word_count,
    output logic              overflow
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Occupancy plus in-flight requests; two extra bits cover up to three
    // outstanding reads on top of a full FIFO.
    localparam int LVL_W = CNT_W + 2;

    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DEPTH);
    localparam logic [LVL_W-1:0] c_lvl_full = LVL_W'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [RD_LATENCY-1:0] r_rd_pipe;
    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [31:0]           r_word_count;
    logic                  r_overflow;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [RD_LATENCY-1:0] w_rd_pipe_nxt;
    logic [LVL_W-1:0]      w_pending;
    logic [LVL_W-1:0]      w_level;
    logic                  w_capture;
    logic                  w_not_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    // The read-latency pipe: a strobe sampled at edge t marks bit 0, and the
    // mark reaches the top bit so that usb_data is captured at edge
    // t + RD_LATENCY, exactly when the FX3 drives the requested word.
    generate
        if (RD_LATENCY == 1) begin : g_pipe_single
            assign w_rd_pipe_nxt = ~slrd;
        end else begin : g_pipe_shift
            assign w_rd_pipe_nxt = {r_rd_pipe[RD_LATENCY-2:0], ~slrd};
        end
    endgenerate

    // Every set bit in the pipe is a word already requested from the FX3
    // that has not been pushed yet, including the one captured this cycle.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_pending = w_pending + LVL_W'(r_rd_pipe[i]);
        end
    end

    assign w_level     = LVL_W'(r_count) + w_pending;
    assign w_capture   = r_rd_pipe[RD_LATENCY-1];
    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == c_cnt_full);

    assign w_pop  = w_not_empty & m_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push = w_capture & (~w_full | w_pop);
    // Only reachable when the controller ignored rx_hold.
    assign w_drop = w_capture & w_full & ~w_pop;

    // Reserving a slot for every in-flight request means a capture can never
    // find the FIFO full as long as the controller obeys the hold.
    assign rx_hold = (w_level >= c_lvl_full);

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pipe    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_rd_pipe <= w_rd_pipe_nxt;

            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + c_ptr_one;
                r_word_count <= r_word_count + 32'd1;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is cleared on reset so the head reads as zero out of reset.
    // When full with a simultaneous pop, the write slot equals the read slot
    // being vacated, so the overwrite is safe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= usb_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign m_data     = r_mem[r_rd_ptr];
    assign m_valid    = w_not_empty;
    assign word_count = r_word_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_rx_stream_buffer
// Description : Self-checking bench for usb_rx_stream_buffer. A queue-based
//               reference model tracks outstanding read requests by the edge
//               at which their word is due and the buffered words as a plain
//               queue; DUT outputs are compared on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_stream_buffer;

    localparam int DATA_W     = 32;
    localparam int DEPTH      = 8;
    localparam int RD_LATENCY = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              slrd = 1'b1;
    logic [DATA_W-1:0] usb_data = '0;
    logic              m_ready = 1'b0;
    logic              rx_hold;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic [31:0]       word_count;
    logic              overflow;

    always #5 clk = ~clk;

    usb_rx_stream_buffer #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .slrd       (slrd),
        .usb_data   (usb_data),
        .rx_hold    (rx_hold),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .word_count (word_count),
        .overflow   (overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [DATA_W-1:0] mq[$];   // buffered words, head first
    int                due[$];  // edge numbers at which requested words arrive
    logic [31:0]       m_wc = '0;
    bit                m_ovf = 1'b0;
    int                edge_no = 0;
    logic [31:0]       next_val = '0;

    function automatic bit model_hold();
        return (mq.size() + due.size()) >= DEPTH;
    endfunction

    function automatic bit capturing();
        return (due.size() != 0) && (due[0] == edge_no + 1);
    endfunction

    function automatic logic [34:0] exp_flags();
        return {model_hold(), (mq.size() != 0), m_ovf, m_wc};
    endfunction

    // Apply the rules to the inputs presented for the coming edge, then
    // advance to the next falling edge.
    task automatic tick();
        int e;
        bit cap, pop, push;
        e = edge_no + 1;
        if (rst) begin
            mq.delete();
            due.delete();
            m_wc  = '0;
            m_ovf = 1'b0;
        end else begin
            pop = (mq.size() != 0) && m_ready;
            cap = capturing();
            if (cap) void'(due.pop_front());
            push = cap && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(usb_data);
                m_wc = m_wc + 32'd1;
            end else if (cap) begin
                m_ovf = 1'b1;
            end
            if (!slrd) due.push_back(e + RD_LATENCY);
        end
        edge_no = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; slrd = 1'b1; m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({rx_hold, m_valid, overflow, word_count} !== exp_flags() || exp_flags() !== 35'd0) begin
            n_err++;
            $display("FAIL reset_flags got=%h exp=%h", {rx_hold, m_valid, overflow, word_count}, 35'd0);
        end
        n_cmp++;
        if (m_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_m_data got=%h exp=%h", m_data, 32'd0);
        end
    endtask

    task automatic test_single_read();
        m_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            slrd     = (c == 0) ? 1'b0 : 1'b1;
            usb_data = capturing() ? 32'hA5A5_0001 : $urandom;
            tick();
            n_cmp++;
            if ({rx_hold, m_valid, overflow, word_count} !== exp_flags()) begin
                n_err++;
                $display("FAIL single_flags edge=%0d got=%h exp=%h", edge_no, {rx_hold, m_valid, overflow, word_count}, exp_flags());
            end
            if (c == 2) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== 32'hA5A5_0001 || word_count !== 32'd1) begin
                    n_err++;
                    $display("FAIL single_capture got valid=%b data=%h count=%0d exp valid=1 data=a5a50001 count=1", m_valid, m_data, word_count);
                end
            end
        end
        slrd = 1'b1; m_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_burst_stalled();
        logic [31:0] wc0;
        wc0 = m_wc;
        next_val = 32'd1;
        m_ready = 1'b0;
        for (int c = 0; c < 14; c++) begin
            slrd = model_hold() ? 1'b1 : 1'b0;
            if (capturing()) begin
                usb_data = next_val;
                next_val = next_val + 32'd1;
            end else begin
                usb_data = $urandom;
            end
            tick();
            n_cmp++;
            if ({rx_hold, m_valid, overflow, word_count} !== exp_flags()) begin
                n_err++;
                $display("FAIL burst_flags edge=%0d got=%h exp=%h", edge_no, {rx_hold, m_valid, overflow, word_count}, exp_flags());
            end
        end
        n_cmp++;
        if (word_count !== wc0 + 32'd8 || rx_hold !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL burst_fill got count=%0d hold=%b ovf=%b exp count=%0d hold=1 ovf=0", word_count, rx_hold, overflow, wc0 + 32'd8);
        end
        slrd = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== 32'(c + 1)) begin
                    n_err++;
                    $display("FAIL burst_drain idx=%0d got valid=%b data=%h exp valid=1 data=%h", c, m_valid, m_data, 32'(c + 1));
                end
            end
            tick();
            n_cmp++;
            if ({rx_hold, m_valid, overflow, word_count} !== exp_flags()) begin
                n_err++;
                $display("FAIL drain_flags edge=%0d got=%h exp=%h", edge_no, {rx_hold, m_valid, overflow, word_count}, exp_flags());
            end
        end
    endtask

    task automatic test_streaming();
        logic [31:0] wc0;
        wc0 = m_wc;
        next_val = 32'h5000_0000;
        m_ready = 1'b1;
        for (int c = 0; c < 106; c++) begin
            slrd = (c < 100) ? 1'b0 : 1'b1;
            if (capturing()) begin
                usb_data = next_val;
                next_val = next_val + 32'd1;
            end else begin
                usb_data = $urandom;
            end
            tick();
            n_cmp++;
            if ({rx_hold, m_valid, overflow, word_count} !== exp_flags()) begin
                n_err++;
                $display("FAIL stream_flags edge=%0d got=%h exp=%h", edge_no, {rx_hold, m_valid, overflow, word_count}, exp_flags());
            end
            if (mq.size() != 0) begin
                n_cmp++;
                if (m_data !== mq[0]) begin
                    n_err++;
                    $display("FAIL stream_data edge=%0d got=%h exp=%h", edge_no, m_data, mq[0]);
                end
            end
        end
        n_cmp++;
        if (word_count !== wc0 + 32'd100 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_total got count=%0d valid=%b exp count=%0d valid=0", word_count, m_valid, wc0 + 32'd100);
        end
    endtask

    // Fill to DEPTH, then force one extra strobe and pop in its capture cycle.
    task automatic test_full_push_pop();
        logic [31:0] wc0;
        wc0 = m_wc;
        next_val = 32'h100;
        m_ready = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (c < 12)       slrd = model_hold() ? 1'b1 : 1'b0;
            else if (c == 12) slrd = 1'b0;
            else              slrd = 1'b1;
            m_ready = (c == 14) ? 1'b1 : 1'b0;
            if (capturing()) begin
                usb_data = next_val;
                next_val = next_val + 32'd1;
            end else begin
                usb_data = $urandom;
            end
            tick();
            n_cmp++;
            if ({rx_hold, m_valid, overflow, word_count} !== exp_flags()) begin
                n_err++;
                $display("FAIL fullpp_flags edge=%0d got=%h exp=%h", edge_no, {rx_hold, m_valid, overflow, word_count}, exp_flags());
            end
            if (mq.size() != 0) begin
                n_cmp++;
                if (m_data !== mq[0]) begin
                    n_err++;
                    $display("FAIL fullpp_data edge=%0d got=%h exp=%h", edge_no, m_data, mq[0]);
                end
            end
        end
        m_ready = 1'b0;
        n_cmp++;
        if (rx_hold !== 1'b1 || overflow !== 1'b0 || word_count !== wc0 + 32'd9 || m_data !== 32'h101) begin
            n_err++;
            $display("FAIL fullpp_result got hold=%b ovf=%b count=%0d head=%h exp hold=1 ovf=0 count=%0d head=00000101",
                     rx_hold, overflow, word_count, m_data, wc0 + 32'd9);
        end
    endtask

    // FIFO is full and stalled; a strobe that ignores rx_hold must be dropped.
    task automatic test_overflow();
        logic [31:0] wc0;
        wc0 = m_wc;
        m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            slrd     = (c == 0) ? 1'b0 : 1'b1;
            usb_data = $urandom;
            tick();
        end
        n_cmp++;
        if (overflow !== 1'b1 || word_count !== wc0 || {rx_hold, m_valid, overflow, word_count} !== exp_flags()) begin
            n_err++;
            $display("FAIL overflow_drop got ovf=%b count=%0d exp ovf=1 count=%0d", overflow, word_count, wc0);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if ({rx_hold, m_valid, overflow, word_count} !== exp_flags()) begin
                n_err++;
                $display("FAIL ovf_drain_flags edge=%0d got=%h exp=%h", edge_no, {rx_hold, m_valid, overflow, word_count}, exp_flags());
            end
            if (mq.size() != 0) begin
                n_cmp++;
                if (m_data !== mq[0]) begin
                    n_err++;
                    $display("FAIL ovf_drain_data edge=%0d got=%h exp=%h", edge_no, m_data, mq[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        m_ready = 1'b0;
        next_val = 32'h7700;
        for (int c = 0; c < 7; c++) begin
            slrd = 1'b0;
            if (capturing()) begin
                usb_data = next_val;
                next_val = next_val + 32'd1;
            end else begin
                usb_data = $urandom;
            end
            tick();
        end
        n_cmp++;
        if (word_count - m_wc !== 32'd0 || mq.size() != 5 || due.size() != 2 || m_data !== 32'h7700) begin
            n_err++;
            $display("FAIL midburst_setup got count=%0d head=%h exp count=%0d head=00007700", word_count, m_data, m_wc);
        end
        rst = 1'b1; slrd = 1'b1; usb_data = $urandom | 32'h1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({rx_hold, m_valid, overflow, word_count} !== 35'd0) begin
            n_err++;
            $display("FAIL midburst_reset got=%h exp=%h", {rx_hold, m_valid, overflow, word_count}, 35'd0);
        end
        for (int c = 0; c < 3; c++) begin
            usb_data = $urandom | 32'h1;
            tick();
            n_cmp++;
            if ({rx_hold, m_valid, overflow, word_count} !== exp_flags()) begin
                n_err++;
                $display("FAIL midburst_stale edge=%0d got=%h exp=%h", edge_no, {rx_hold, m_valid, overflow, word_count}, exp_flags());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            slrd     = model_hold() ? 1'b1 : (($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1);
            m_ready  = (c < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            usb_data = $urandom;
            tick();
            n_cmp++;
            if ({rx_hold, m_valid, overflow, word_count} !== exp_flags()) begin
                n_err++;
                $display("FAIL random_flags edge=%0d got=%h exp=%h", edge_no, {rx_hold, m_valid, overflow, word_count}, exp_flags());
            end
            if (mq.size() != 0) begin
                n_cmp++;
                if (m_data !== mq[0]) begin
                    n_err++;
                    $display("FAIL random_data edge=%0d got=%h exp=%h", edge_no, m_data, mq[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst_stalled();
        test_streaming();
        test_full_push_pop();
        test_overflow();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
